mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous-read memory between the pipelined MIPS core's instruction-fetch port and its data (load/store) port, replacing the separate instruction and data memories with one unified memory. Each requester uses a req/ready handshake. The memory side is a block-RAM port with one-cycle read latency. Data accesses have priority, and a streak counter guarantees fetch forward progress. A fetch-flush input cancels an in-flight fetch on a taken branch.

## Interface
Parameters:
- ADDR_W, 32, byte-address width passed unchanged to the memory
- DATA_W, 32, data word width
- D_STREAK_MAX, 4, maximum consecutive data grants while a fetch is waiting (≥1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr until i_ready
- i_addr  in  ADDR_W  fetch address (PC)
- i_flush  in  1  cancel the outstanding fetch (taken branch/jump)
- i_ready  out  1  fetch complete; i_rdata valid this cycle
- i_rdata  out  DATA_W  instruction word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  data access complete; d_rdata valid this cycle for loads
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data; valid the cycle after an enabled read

## Operation
- States: IDLE (nothing outstanding), I_WAIT (fetch issued last cycle), D_WAIT (data access issued last cycle). At most one access is outstanding.
- Eligibility each cycle:
  - fetch eligible = i_req && state != I_WAIT
  - data eligible = d_req && state != D_WAIT
  - A requester being completed this cycle is never re-granted in the same cycle.
- Winner selection:
  - Data wins, unless the fetch is eligible and d_streak == D_STREAK_MAX; then the fetch wins.
  - If only one requester is eligible, it wins.
  - If neither is eligible, there is no grant.
- Grant cycle (combinational):
  - mem_en=1 and mem_addr = winner's address.
  - Data winner: mem_we=d_we, mem_din=d_wdata.
  - Fetch winner: mem_we=0.
  - No grant: mem_en=0, mem_we=0.
  - Next state = I_WAIT or D_WAIT for the winner, else IDLE.
- Completion cycle: the cycle in state X_WAIT.
  - X_ready=1, and X_rdata = mem_dout.
  - Stores also complete with d_ready one cycle after grant.
- i_rdata and d_rdata are both wired to mem_dout. They are meaningful only while their ready signal is high.
- Flush:
  - i_flush=1 while in I_WAIT suppresses i_ready; the fetched word is discarded.
  - i_flush in any other state has no effect.
  - i_flush never blocks a new fetch grant.
- d_streak (counter, saturates at D_STREAK_MAX):
  - Increments on a data grant while i_req=1.
  - Clears on a fetch grant, or on any cycle with i_req=0.
- Reset (asserted at any time, including mid-access):
  - state=IDLE, d_streak=0, and any outstanding access is discarded.
  - While rst=1: mem_en=0, mem_we=0, i_ready=0, d_ready=0.
  - No ready is issued for the discarded access after release.
- Reset values:
  - i_ready=0, d_ready=0, mem_en=0, mem_we=0.
  - mem_addr and mem_din follow the inputs and are don't-care.
  - i_rdata and d_rdata mirror mem_dout.

## Timing
- Latency: grant in cycle T, ready in T+1, for loads, stores and fetches.
- Throughput:
  - 1 access/cycle when requests alternate between the two ports.
  - 1 access per 2 cycles for back-to-back requests from the same port.
- Simultaneous requests: data is granted at T, fetch at T+1 (fetch is then eligible because state = D_WAIT).
- Requesters must not change their address or data while req is high and ready has not yet been returned.
- No combinational path from mem_dout to any mem_* output.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum: ARB_IDLE, ARB_I_WAIT, ARB_D_WAIT
  - ARB_STREAK_W = $clog2(D_STREAK_MAX+1)
- One natural sub-module: streak_counter (saturating counter with increment and clear inputs).
- The remainder is a single always block for state, plus combinational grant/mux logic.

## Test plan
- Single fetch, i_addr=0x00000004 with memory word 0x20080005: mem_en=1 at T, i_ready=1 with i_rdata=0x20080005 at T+1, state IDLE at T+2.
- i_req and d_req (store to 0x40, data 0xDEADBEEF) both held high:
  - Data granted at T, fetch at T+1.
  - A load from 0x40 then returns 0xDEADBEEF.
- d_req held continuously with i_req high, D_STREAK_MAX=4: data granted at most 4 consecutive times, then a fetch grant; pattern repeats.
- i_flush=1 during I_WAIT: i_ready stays 0; the next fetch to the branch target 0x100 is granted and completes with its word 2 cycles later.
- rst pulsed during D_WAIT of a load: d_ready never asserts and mem_en=0 during reset. After release, d_req is granted anew from IDLE.
- Same-port back-to-back fetches 0x0, 0x4, 0x8 with d_req=0: grants at T, T+2, T+4; i_ready at T+1, T+3, T+5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
// Holds the arbiter state encoding and streak-counter sizing helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I_WAIT,
        ARB_D_WAIT
    } arb_state_e;

    localparam int ARB_D_STREAK_MAX = 4;
    localparam int ARB_STREAK_W = $clog2(ARB_D_STREAK_MAX + 1);

    // Counter width for an arbitrary streak limit set by the instantiating module.
    function automatic int arb_streak_w(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/streak_counter.sv
// Saturating up-counter with synchronous clear, used to bound how many
// consecutive data grants may starve a waiting instruction fetch.
module streak_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic at_max;

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous-read memory between the fetch port
// and the load/store port; data has priority, bounded by a streak counter.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int SW = arb_streak_w(D_STREAK_MAX);

    arb_state_e state, state_next;

    logic          fetch_elig;
    logic          data_elig;
    logic          grant_i;
    logic          grant_d;
    logic          streak_full;
    logic [SW-1:0] d_streak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A port whose access completes this cycle is not eligible again yet.
    always_comb begin
        fetch_elig  = i_req && (state != ARB_I_WAIT);
        data_elig   = d_req && (state != ARB_D_WAIT);
        streak_full = (d_streak == SW'(D_STREAK_MAX));
        grant_i     = fetch_elig && (!data_elig || streak_full);
        grant_d     = data_elig && !grant_i;
    end

    always_comb begin
        state_next = ARB_IDLE;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = d_addr;
        mem_din    = d_wdata;
        if (grant_d) begin
            state_next = ARB_D_WAIT;
            mem_en     = 1'b1;
            mem_we     = d_we;
        end else if (grant_i) begin
            state_next = ARB_I_WAIT;
            mem_en     = 1'b1;
            mem_addr   = i_addr;
        end
        if (rst) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    // A flush during the fetch completion cycle drops the fetched word.
    assign i_ready = !rst && (state == ARB_I_WAIT) && !i_flush;
    assign d_ready = !rst && (state == ARB_D_WAIT);
    assign i_rdata = mem_dout;
    assign d_rdata = mem_dout;

    streak_counter #(
        .MAX(D_STREAK_MAX),
        .W  (SW)
    ) u_streak (
        .clk  (clk),
        .rst  (rst),
        .inc  (grant_d && i_req),
        .clr  (grant_i || !i_req),
        .count(d_streak)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a
// transaction-level reference model checked every cycle.
module tb_mem_port_arbiter;

    localparam int D_MAX = 4;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .D_STREAK_MAX(D_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_flush (i_flush),
        .i_ready (i_ready),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ready (d_ready),
        .d_rdata (d_rdata),
        .mem_en  (mem_en),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM: read-first, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_din;
            mem_dout <= mem[mem_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which port (0 none, 1 fetch, 2 data) owns the
    // outstanding access, what word it must return, and the data streak.
    int          pend = 0;
    int          streak = 0;
    int          win;
    bit          pend_load;
    logic [31:0] pend_word;
    bit          f_ok, d_ok, e_i, e_d;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_i_ready", i_ready, 0);
            chk("rst_d_ready", d_ready, 0);
            pend   = 0;
            streak = 0;
        end else begin
            e_i = (pend == 1) && !i_flush;
            e_d = (pend == 2);
            chk("m_i_ready", i_ready, e_i);
            chk("m_d_ready", d_ready, e_d);
            if (e_i) chk("m_i_rdata", i_rdata, pend_word);
            if (e_d && pend_load) chk("m_d_rdata", d_rdata, pend_word);
            f_ok = i_req && (pend != 1);
            d_ok = d_req && (pend != 2);
            win = 0;
            if (f_ok && (!d_ok || streak == D_MAX)) win = 1;
            else if (d_ok) win = 2;
            chk("m_mem_en", mem_en, win != 0);
            if (win == 1) begin
                chk("m_mem_we_f", mem_we, 0);
                chk("m_mem_addr_f", mem_addr, i_addr);
                pend_word = ref_mem[i_addr[9:2]];
            end else if (win == 2) begin
                chk("m_mem_we_d", mem_we, d_we);
                chk("m_mem_addr_d", mem_addr, d_addr);
                if (d_we) chk("m_mem_din", mem_din, d_wdata);
                pend_word = ref_mem[d_addr[9:2]];
                pend_load = !d_we;
                if (d_we) ref_mem[d_addr[9:2]] = d_wdata;
            end else begin
                chk("m_mem_we_idle", mem_we, 0);
            end
            if (win == 1 || !i_req) streak = 0;
            else if (win == 2 && streak < D_MAX) streak++;
            pend = win;
        end
    end

    // Tasks start and end just after a rising edge.
    task automatic fetch(input logic [31:0] a, input logic [31:0] w,
                         input int ec);
        int n;
        bit got;
        n = 0;
        got = 0;
        i_req = 1'b1;
        i_addr = a;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (i_ready) begin
                got = 1;
                chk("fetch_word", i_rdata, w);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: no i_ready for addr %h", a);
        end else begin
            if (ec != 0) chk("fetch_latency", n, ec);
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
    endtask

    task automatic data(input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] w,
                        input int ec);
        int n;
        bit got;
        n = 0;
        got = 0;
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (d_ready) begin
                got = 1;
                if (!we) chk("load_word", d_rdata, w);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL data_timeout: no d_ready for addr %h", a);
        end else begin
            if (ec != 0) chk("data_latency", n, ec);
            @(posedge clk);
            #1;
        end
        d_req = 1'b0;
    endtask

    int max_run, run, fetch_cnt;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[1]  = 32'h2008_0005;
        mem[16] = 32'h0000_0000;
        mem[64] = 32'h0800_0010;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        rst = 1'b1;
        i_req = 0; i_addr = 0; i_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_i_ready", i_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single fetch.
        fork
            fetch(32'h4, 32'h2008_0005, 2);
            begin
                @(negedge clk);
                chk("t1_grant_en", mem_en, 1);
                chk("t1_grant_addr", mem_addr, 32'h4);
            end
        join
        @(negedge clk);
        chk("t1_idle_en", mem_en, 0);
        chk("t1_idle_i_ready", i_ready, 0);
        @(posedge clk);
        #1;

        // Simultaneous store and fetch: data first, fetch next cycle.
        fork
            data(1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 2);
            fetch(32'h0, 32'h1000_0000, 3);
            begin
                @(negedge clk);
                chk("t2_d_grant_we", mem_we, 1);
                chk("t2_d_grant_addr", mem_addr, 32'h40);
                @(negedge clk);
                chk("t2_f_grant_addr", mem_addr, 32'h0);
                chk("t2_f_grant_we", mem_we, 0);
                chk("t2_store_ready", d_ready, 1);
            end
        join
        data(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 2);

        // Both ports requesting continuously.
        max_run = 0;
        run = 0;
        fetch_cnt = 0;
        fork
            repeat (6) fetch(32'h0, 32'h1000_0000, 0);
            repeat (6) data(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);
            repeat (12) begin
                @(negedge clk);
                if (mem_en && mem_addr == 32'h40) begin
                    run++;
                    if (run > max_run) max_run = run;
                end else if (mem_en) begin
                    run = 0;
                    fetch_cnt++;
                end
            end
        join
        chk("streak_run_bounded", max_run <= D_MAX, 1);
        chk("streak_fetch_served", fetch_cnt >= 1, 1);

        // Flush during fetch completion, then fetch the branch target.
        i_req = 1'b1;
        i_addr = 32'h8;
        @(negedge clk);
        chk("fl_grant_addr", mem_addr, 32'h8);
        @(posedge clk);
        #1;
        i_flush = 1'b1;
        i_addr = 32'h100;
        @(negedge clk);
        chk("fl_suppressed", i_ready, 0);
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        @(negedge clk);
        chk("fl_target_en", mem_en, 1);
        chk("fl_target_addr", mem_addr, 32'h100);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fl_target_ready", i_ready, 1);
        chk("fl_target_word", i_rdata, 32'h0800_0010);
        @(posedge clk);
        #1;
        i_req = 1'b0;

        // Reset in the middle of a load.
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h40;
        @(negedge clk);
        chk("rs_grant_en", mem_en, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rs_no_ready", d_ready, 0);
        chk("rs_no_en", mem_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs_regrant_en", mem_en, 1);
        chk("rs_regrant_addr", mem_addr, 32'h40);
        chk("rs_stale_ready", d_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rs_ready", d_ready, 1);
        chk("rs_word", d_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        d_req = 1'b0;

        // Back-to-back fetches from the same port.
        fetch(32'h0, 32'h1000_0000, 2);
        fetch(32'h4, 32'h2008_0005, 2);
        fetch(32'h8, 32'h1000_0002, 2);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: bench did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
